// File: rtl/udma_uart_cfg_sequencer_pkg.sv
// Shared register map, sequencer states and write-table helpers for the udma_uart
// cfg sequencer.
package udma_uart_cfg_pkg;

    localparam logic [4:0] REG_RX_SADDR = 5'h00;
    localparam logic [4:0] REG_RX_SIZE  = 5'h01;
    localparam logic [4:0] REG_RX_CFG   = 5'h02;
    localparam logic [4:0] REG_TX_SADDR = 5'h04;
    localparam logic [4:0] REG_TX_SIZE  = 5'h05;
    localparam logic [4:0] REG_TX_CFG   = 5'h06;
    localparam logic [4:0] REG_STATUS   = 5'h08;
    localparam logic [4:0] REG_SETUP    = 5'h09;

    localparam int CFG_EN_BIT   = 4;
    localparam int CFG_CONT_BIT = 0;

    // Write-table entry index; ENT_END marks "no more writes".
    localparam logic [2:0] ENT_SETUP    = 3'd0;
    localparam logic [2:0] ENT_RX_SADDR = 3'd1;
    localparam logic [2:0] ENT_RX_SIZE  = 3'd2;
    localparam logic [2:0] ENT_RX_CFG   = 3'd3;
    localparam logic [2:0] ENT_TX_SADDR = 3'd4;
    localparam logic [2:0] ENT_TX_SIZE  = 3'd5;
    localparam logic [2:0] ENT_TX_CFG   = 3'd6;
    localparam logic [2:0] ENT_END      = 3'd7;

    typedef enum logic [2:0] {IDLE, WRITE, POLL_RD, POLL_WAIT, DONE} seq_state_e;

    function automatic logic [2:0] next_entry(input logic [2:0] cur, input logic rx_en,
                                              input logic tx_en);
        logic [2:0] nxt;
        case (cur)
            ENT_SETUP:    nxt = rx_en ? ENT_RX_SADDR : (tx_en ? ENT_TX_SADDR : ENT_END);
            ENT_RX_SADDR: nxt = ENT_RX_SIZE;
            ENT_RX_SIZE:  nxt = ENT_RX_CFG;
            ENT_RX_CFG:   nxt = tx_en ? ENT_TX_SADDR : ENT_END;
            ENT_TX_SADDR: nxt = ENT_TX_SIZE;
            ENT_TX_SIZE:  nxt = ENT_TX_CFG;
            default:      nxt = ENT_END;
        endcase
        return nxt;
    endfunction

    function automatic logic [4:0] entry_addr(input logic [2:0] ent);
        logic [4:0] a;
        case (ent)
            ENT_RX_SADDR: a = REG_RX_SADDR;
            ENT_RX_SIZE:  a = REG_RX_SIZE;
            ENT_RX_CFG:   a = REG_RX_CFG;
            ENT_TX_SADDR: a = REG_TX_SADDR;
            ENT_TX_SIZE:  a = REG_TX_SIZE;
            ENT_TX_CFG:   a = REG_TX_CFG;
            default:      a = REG_SETUP;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] cfg_word(input logic cont);
        logic [31:0] w;
        w               = '0;
        w[CFG_EN_BIT]   = 1'b1;
        w[CFG_CONT_BIT] = cont;
        return w;
    endfunction

endpackage

// File: rtl/udma_uart_cfg_sequencer_bus.sv
// Single-request cfg bus master: a req loads one transfer that is held until the
// slave accepts it; a new req in the accept cycle gives back-to-back transfers.
module udma_cfg_bus_master (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        req_rwn_i,
    input  logic [4:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        cfg_valid_o,
    output logic        cfg_rwn_o,
    output logic [4:0]  cfg_addr_o,
    output logic [31:0] cfg_data_o,
    input  logic        cfg_ready_i,
    input  logic [31:0] cfg_data_i
);

    logic        valid_q, valid_d;
    logic        rwn_q, rwn_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    assign ack_o   = valid_q & cfg_ready_i;
    assign rdata_o = cfg_data_i;

    always_comb begin
        valid_d = valid_q;
        rwn_d   = rwn_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (req_i) begin
            valid_d = 1'b1;
            rwn_d   = req_rwn_i;
            addr_d  = req_addr_i;
            data_d  = req_wdata_i;
        end else if (ack_o) begin
            valid_d = 1'b0;
            rwn_d   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rwn_q   <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rwn_q   <= rwn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign cfg_valid_o = valid_q;
    assign cfg_rwn_o   = rwn_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_data_o  = data_q;

endmodule

// File: rtl/udma_uart_cfg_sequencer.sv
// Programs udma_uart SETUP and RX/TX channel registers from one start pulse, then
// optionally polls STATUS until the UART reports idle or the poll budget runs out.
module udma_uart_cfg_sequencer
    import udma_uart_cfg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20,
    parameter int POLL_GAP       = 16,
    parameter int POLL_MAX       = 1024
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [31:0]               setup_i,
    input  logic                      rx_en_i,
    input  logic                      rx_cont_i,
    input  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_i,
    input  logic [TRANS_SIZE-1:0]     rx_size_i,
    input  logic                      tx_en_i,
    input  logic                      tx_cont_i,
    input  logic [L2_AWIDTH_NOAL-1:0] tx_saddr_i,
    input  logic [TRANS_SIZE-1:0]     tx_size_i,
    input  logic                      wait_idle_i,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    output logic [4:0]                cfg_addr_o,
    output logic [31:0]               cfg_data_o,
    input  logic                      cfg_ready_i,
    input  logic [31:0]               cfg_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [31:0]               status_o
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    seq_state_e                state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic                      rx_en_q, rx_en_d, rx_cont_q, rx_cont_d;
    logic                      tx_en_q, tx_en_d, tx_cont_q, tx_cont_d;
    logic                      wait_idle_q, wait_idle_d;
    logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, rx_saddr_d, tx_saddr_q, tx_saddr_d;
    logic [TRANS_SIZE-1:0]     rx_size_q, rx_size_d, tx_size_q, tx_size_d;
    logic [PCW-1:0]            poll_cnt_q, poll_cnt_d, poll_cnt_inc;
    logic [GCW-1:0]            gap_cnt_q, gap_cnt_d;
    logic                      err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic [31:0]               status_q, status_d;

    logic                      req, req_rwn, ack;
    logic [4:0]                req_addr;
    logic [31:0]               req_wdata, rdata, ent_wdata;
    logic [2:0]                ent_nxt;

    assign ent_nxt      = next_entry(idx_q, rx_en_q, tx_en_q);
    assign poll_cnt_inc = poll_cnt_q + PCW'(1);

    always_comb begin
        case (ent_nxt)
            ENT_RX_SADDR: ent_wdata = 32'(rx_saddr_q);
            ENT_RX_SIZE:  ent_wdata = 32'(rx_size_q);
            ENT_RX_CFG:   ent_wdata = cfg_word(rx_cont_q);
            ENT_TX_SADDR: ent_wdata = 32'(tx_saddr_q);
            ENT_TX_SIZE:  ent_wdata = 32'(tx_size_q);
            ENT_TX_CFG:   ent_wdata = cfg_word(tx_cont_q);
            default:      ent_wdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rx_en_d     = rx_en_q;
        rx_cont_d   = rx_cont_q;
        rx_saddr_d  = rx_saddr_q;
        rx_size_d   = rx_size_q;
        tx_en_d     = tx_en_q;
        tx_cont_d   = tx_cont_q;
        tx_saddr_d  = tx_saddr_q;
        tx_size_d   = tx_size_q;
        wait_idle_d = wait_idle_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        status_d    = status_q;
        req         = 1'b0;
        req_rwn     = 1'b0;
        req_addr    = REG_SETUP;
        req_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rx_en_d     = rx_en_i;
                    rx_cont_d   = rx_cont_i;
                    rx_saddr_d  = rx_saddr_i;
                    rx_size_d   = rx_size_i;
                    tx_en_d     = tx_en_i;
                    tx_cont_d   = tx_cont_i;
                    tx_saddr_d  = tx_saddr_i;
                    tx_size_d   = tx_size_i;
                    wait_idle_d = wait_idle_i;
                    idx_d       = ENT_SETUP;
                    poll_cnt_d  = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    req         = 1'b1;
                    req_wdata   = setup_i;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (ack) begin
                    if (ent_nxt != ENT_END) begin
                        idx_d     = ent_nxt;
                        req       = 1'b1;
                        req_addr  = entry_addr(ent_nxt);
                        req_wdata = ent_wdata;
                    end else if (wait_idle_q) begin
                        req      = 1'b1;
                        req_rwn  = 1'b1;
                        req_addr = REG_STATUS;
                        state_d  = POLL_RD;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            POLL_RD: begin
                if (ack) begin
                    status_d = rdata;
                    if (rdata[1:0] == 2'b00) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else if (poll_cnt_inc == PCW'(POLL_MAX)) begin
                        poll_cnt_d = poll_cnt_inc;
                        err_d      = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = DONE;
                    end else begin
                        poll_cnt_d = poll_cnt_inc;
                        gap_cnt_d  = GCW'(POLL_GAP - 1);
                        state_d    = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                // Terminal count issues the next read so it lands POLL_GAP idle cycles later.
                if (gap_cnt_q == '0) begin
                    req      = 1'b1;
                    req_rwn  = 1'b1;
                    req_addr = REG_STATUS;
                    state_d  = POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q - GCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= ENT_SETUP;
            rx_en_q     <= 1'b0;
            rx_cont_q   <= 1'b0;
            rx_saddr_q  <= '0;
            rx_size_q   <= '0;
            tx_en_q     <= 1'b0;
            tx_cont_q   <= 1'b0;
            tx_saddr_q  <= '0;
            tx_size_q   <= '0;
            wait_idle_q <= 1'b0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rx_en_q     <= rx_en_d;
            rx_cont_q   <= rx_cont_d;
            rx_saddr_q  <= rx_saddr_d;
            rx_size_q   <= rx_size_d;
            tx_en_q     <= tx_en_d;
            tx_cont_q   <= tx_cont_d;
            tx_saddr_q  <= tx_saddr_d;
            tx_size_q   <= tx_size_d;
            wait_idle_q <= wait_idle_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            status_q    <= status_d;
        end
    end

    udma_cfg_bus_master u_bus (
        .sys_clk_i   (sys_clk_i),
        .rst_i       (rst_i),
        .req_i       (req),
        .req_rwn_i   (req_rwn),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .cfg_valid_o (cfg_valid_o),
        .cfg_rwn_o   (cfg_rwn_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_data_i  (cfg_data_i)
    );

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_udma_uart_cfg_sequencer.sv
// Randomized scoreboard bench for udma_uart_cfg_sequencer: expected cfg transfers are
// queued from a register-list model and popped by an independent bus monitor.
module tb_udma_uart_cfg_sequencer;

    localparam int AW   = 19;
    localparam int SW   = 20;
    localparam int GAP  = 3;
    localparam int PMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   setup_i = '0;
    logic          rx_en_i = 1'b0, rx_cont_i = 1'b0, tx_en_i = 1'b0, tx_cont_i = 1'b0;
    logic [AW-1:0] rx_saddr_i = '0, tx_saddr_i = '0;
    logic [SW-1:0] rx_size_i = '0, tx_size_i = '0;
    logic          wait_idle_i = 1'b0;
    logic          cfg_valid_o, cfg_rwn_o, cfg_ready_i;
    logic [4:0]    cfg_addr_o;
    logic [31:0]   cfg_data_o, cfg_data_i, status_o;
    logic          busy_o, done_o, err_o;

    always #5 clk = ~clk;

    udma_uart_cfg_sequencer #(
        .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(SW), .POLL_GAP(GAP), .POLL_MAX(PMAX)
    ) dut (
        .sys_clk_i(clk), .rst_i(rst), .start_i(start_i), .setup_i(setup_i),
        .rx_en_i(rx_en_i), .rx_cont_i(rx_cont_i), .rx_saddr_i(rx_saddr_i), .rx_size_i(rx_size_i),
        .tx_en_i(tx_en_i), .tx_cont_i(tx_cont_i), .tx_saddr_i(tx_saddr_i), .tx_size_i(tx_size_i),
        .wait_idle_i(wait_idle_i), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
        .cfg_data_i(cfg_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .status_o(status_o)
    );

    typedef struct {
        logic        rwn;
        logic [4:0]  addr;
        logic [31:0] data;
    } xact_t;

    typedef struct {
        logic          rxe, txe, rxc, txc, wi;
        logic [31:0]   setup;
        logic [AW-1:0] rsa, tsa;
        logic [SW-1:0] rsz, tsz;
        int            mode;
        bit            poke;
    } seq_t;

    xact_t       exp_q[$];
    logic [31:0] stat_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    bit          gap_chk = 1'b0;
    int          last_rd_cyc = -1;
    logic [31:0] model_status = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Slave: ready pattern per mode, read data from the STATUS script.
    initial begin
        bit pop;
        cfg_ready_i = 1'b0;
        cfg_data_i  = '0;
        forever begin
            @(negedge clk);
            pop = cfg_valid_o && cfg_ready_i && cfg_rwn_o && !rst;
            @(posedge clk);
            #2;
            if (pop && stat_q.size() > 0) void'(stat_q.pop_front());
            case (ready_mode)
                0:       cfg_ready_i = 1'b1;
                1:       cfg_ready_i = ~cfg_ready_i;
                default: cfg_ready_i = 1'($urandom_range(0, 1));
            endcase
            cfg_data_i = (stat_q.size() > 0) ? stat_q[0] : 32'h0;
        end
    end

    // Monitor: holds while stalled, and pops the scoreboard on every transfer.
    initial begin
        logic        pv, pr, prwn;
        logic [4:0]  pa;
        logic [31:0] pd;
        xact_t       e;
        pv = 1'b0;
        pr = 1'b0;
        prwn = 1'b1;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(cfg_valid_o), 32'd1);
                chk("hold_addr", 32'(cfg_addr_o), 32'(pa));
                chk("hold_data", cfg_data_o, pd);
                chk("hold_rwn", 32'(cfg_rwn_o), 32'(prwn));
            end
            if (cfg_valid_o && cfg_ready_i) begin
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_rwn", 32'(cfg_rwn_o), 32'(e.rwn));
                    chk("xfer_addr", 32'(cfg_addr_o), 32'(e.addr));
                    if (!e.rwn) chk("xfer_wdata", cfg_data_o, e.data);
                    if (cfg_rwn_o) begin
                        if (gap_chk && last_rd_cyc >= 0)
                            chk("poll_spacing", 32'(cyc - last_rd_cyc), 32'(GAP + 1));
                        last_rd_cyc = cyc;
                    end
                end
            end
            pv = cfg_valid_o;
            pr = cfg_ready_i;
            pa = cfg_addr_o;
            pd = cfg_data_o;
            prwn = cfg_rwn_o;
        end
    end

    function automatic xact_t wr(input logic [4:0] a, input logic [31:0] d);
        xact_t x;
        x.rwn = 1'b0;
        x.addr = a;
        x.data = d;
        return x;
    endfunction

    task automatic scramble_inputs();
        setup_i    = $urandom;
        rx_en_i    = 1'($urandom);
        rx_cont_i  = 1'($urandom);
        tx_en_i    = 1'($urandom);
        tx_cont_i  = 1'($urandom);
        rx_saddr_i = AW'($urandom);
        tx_saddr_i = AW'($urandom);
        rx_size_i  = SW'($urandom);
        tx_size_i  = SW'($urandom);
        wait_idle_i = 1'($urandom);
    endtask

    task automatic run_seq(input seq_t s);
        int          nw, reads, c0;
        bit          got, exp_err;
        logic [31:0] exp_status;
        xact_t       rd;
        exp_q.delete();
        exp_q.push_back(wr(5'h09, s.setup));
        if (s.rxe) begin
            exp_q.push_back(wr(5'h00, 32'(s.rsa)));
            exp_q.push_back(wr(5'h01, 32'(s.rsz)));
            exp_q.push_back(wr(5'h02, 32'h10 + 32'(s.rxc)));
        end
        if (s.txe) begin
            exp_q.push_back(wr(5'h04, 32'(s.tsa)));
            exp_q.push_back(wr(5'h05, 32'(s.tsz)));
            exp_q.push_back(wr(5'h06, 32'h10 + 32'(s.txc)));
        end
        nw = exp_q.size();
        exp_err = 1'b0;
        exp_status = model_status;
        if (s.wi) begin
            reads = 0;
            for (int i = 0; i < PMAX; i++) begin
                reads++;
                exp_status = (i < stat_q.size()) ? stat_q[i] : 32'h0;
                if (exp_status[1:0] == 2'b00) break;
            end
            exp_err = (exp_status[1:0] != 2'b00);
            rd.rwn = 1'b1;
            rd.addr = 5'h08;
            rd.data = '0;
            for (int i = 0; i < reads; i++) exp_q.push_back(rd);
        end

        @(posedge clk);
        #1;
        ready_mode  = s.mode;
        gap_chk     = (s.mode == 0);
        last_rd_cyc = -1;
        setup_i = s.setup;
        rx_en_i = s.rxe;  rx_cont_i = s.rxc;  rx_saddr_i = s.rsa;  rx_size_i = s.rsz;
        tx_en_i = s.txe;  tx_cont_i = s.txc;  tx_saddr_i = s.tsa;  tx_size_i = s.tsz;
        wait_idle_i = s.wi;
        start_i = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        scramble_inputs();
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("valid_after_start", 32'(cfg_valid_o), 32'd1);
        chk("err_cleared_on_start", 32'(err_o), 32'd0);

        got = 1'b0;
        for (int n = 0; n < 2000 && !got; n++) begin
            if (done_o) got = 1'b1;
            else begin
                start_i = s.poke && (n == 2);
                @(posedge clk);
                #1;
            end
        end
        start_i = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("busy_at_done", 32'(busy_o), 32'd0);
        chk("err_at_done", 32'(err_o), 32'(exp_err));
        chk("status_at_done", status_o, exp_status);
        chk("pending_xfers", 32'(exp_q.size()), 32'd0);
        if (s.mode == 0 && !s.wi) chk("done_latency", 32'(cyc - c0), 32'(nw + 1));
        model_status = exp_status;
        if (s.poke) start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("idle_after_done", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        chk("no_restart_valid", 32'(cfg_valid_o), 32'd0);
        chk("no_restart_busy", 32'(busy_o), 32'd0);
        chk("rwn_idle", 32'(cfg_rwn_o), 32'd1);
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(cfg_valid_o), 32'd0);
        chk("rst_rwn", 32'(cfg_rwn_o), 32'd1);
        chk("rst_addr", 32'(cfg_addr_o), 32'd0);
        chk("rst_data", cfg_data_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_status", status_o, 32'd0);
    endtask

    initial begin
        seq_t s;
        int   vcnt;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // 1: RX only, ready tied high
        s = '{rxe:1, txe:0, rxc:0, txc:0, wi:0, setup:32'h01B20306, rsa:19'h934, tsa:19'h0,
              rsz:20'h80, tsz:20'h0, mode:0, poke:0};
        stat_q.delete();
        run_seq(s);

        // 2: both channels, TX continuous, toggling ready
        s = '{rxe:1, txe:1, rxc:0, txc:1, wi:0, setup:32'hA5A50001, rsa:19'h12345, tsa:19'h7FFFF,
              rsz:20'hFFFFF, tsz:20'h00010, mode:1, poke:0};
        run_seq(s);

        // 3: STATUS 3,3,0
        s = '{rxe:0, txe:1, rxc:0, txc:0, wi:1, setup:32'h00000306, rsa:19'h0, tsa:19'h400,
              rsz:20'h0, tsz:20'h20, mode:0, poke:0};
        stat_q.delete();
        stat_q.push_back(32'h3); stat_q.push_back(32'h3); stat_q.push_back(32'h0);
        run_seq(s);

        // 4: STATUS stuck busy -> timeout
        s.wi = 1'b1;
        s.rxe = 1'b1;
        stat_q.delete();
        for (int i = 0; i < 6; i++) stat_q.push_back(32'h1);
        run_seq(s);

        // 5: start during busy and on the DONE cycle; also clears err
        s = '{rxe:1, txe:1, rxc:1, txc:0, wi:0, setup:32'h11112222, rsa:19'h00100, tsa:19'h00200,
              rsz:20'h00300, tsz:20'h00400, mode:0, poke:1};
        run_seq(s);

        // 6: reset while write #3 is on the bus
        s = '{rxe:1, txe:1, rxc:0, txc:0, wi:1, setup:32'h0, rsa:19'h1, tsa:19'h2,
              rsz:20'h3, tsz:20'h4, mode:0, poke:0};
        stat_q.delete();
        for (int i = 0; i < 6; i++) stat_q.push_back(32'h2);
        run_seq(s);
        s.wi = 1'b0;
        @(posedge clk);
        #1;
        ready_mode = 0;
        setup_i = 32'h5; rx_en_i = 1'b1; tx_en_i = 1'b1; wait_idle_i = 1'b0;
        exp_q.delete();
        exp_q.push_back(wr(5'h09, 32'h5));
        exp_q.push_back(wr(5'h00, 32'(rx_saddr_i)));
        start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values();
        exp_q.delete();
        model_status = '0;
        rst = 1'b0;
        vcnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cfg_valid_o) vcnt++;
        end
        chk("no_cfg_after_reset", 32'(vcnt), 32'd0);

        // randomized sequences
        for (int k = 0; k < 40; k++) begin
            s.rxe = 1'($urandom);  s.txe = 1'($urandom);
            s.rxc = 1'($urandom);  s.txc = 1'($urandom);
            s.wi  = 1'($urandom);  s.setup = $urandom;
            s.rsa = AW'($urandom); s.tsa = AW'($urandom);
            s.rsz = SW'($urandom); s.tsz = SW'($urandom);
            s.mode = $urandom_range(0, 2);
            s.poke = 1'b0;
            stat_q.delete();
            for (int i = 0; i < 6; i++) begin
                logic [31:0] v;
                v = $urandom;
                if ($urandom_range(0, 2) == 0) v[1:0] = 2'b00;
                else if (v[1:0] == 2'b00) v[0] = 1'b1;
                stat_q.push_back(v);
            end
            run_seq(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
